// File: rtl/wb_cp0_stage.sv
// Writeback stage with built-in CP0 (Status, Cause, EPC, BadVAddr, Count, Compare).
// Commits GPR writes, resolves exceptions/eret at commit and raises the timer interrupt.
module wb_cp0_stage #(
    parameter logic [31:0] EX_ENTRY   = 32'hbfc00380,
    parameter logic [31:0] STATUS_RST = 32'h00400000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_to_ws_valid,
    input  logic [121:0] ms_to_ws_bus,
    input  logic [5:0]   ext_int_in,
    output logic         ws_allowin,
    output logic [37:0]  ws_to_rf_bus,
    output logic [36:0]  back_to_mem_stage_bus_from_wb,
    output logic [38:0]  back_to_id_stage_bus_from_wb,
    output logic [33:0]  exception_bus,
    output logic [31:0]  debug_wb_pc,
    output logic [3:0]   debug_wb_rf_wen,
    output logic [4:0]   debug_wb_rf_wnum,
    output logic [31:0]  debug_wb_rf_wdata
);

    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;

    typedef enum logic [1:0] {
        BV_KEEP = 2'd0,
        BV_PC   = 2'd1,
        BV_ADDR = 2'd2
    } bv_sel_t;

    logic         ws_valid_r;
    logic [121:0] bus_r;

    logic [31:0]  bad_vaddr_s;
    logic         in_slot_s;
    logic         ex_int_s;
    logic         adel_if_s;
    logic         adel_exe_s;
    logic         rsv_s;
    logic         ov_s;
    logic         sys_s;
    logic         brk_s;
    logic         ades_s;
    logic [7:0]   cp0_addr_s;
    logic         eret_s;
    logic         mfc0_s;
    logic         mtc0_s;
    logic         gr_we_s;
    logic [4:0]   dest_s;
    logic [31:0]  result_s;
    logic [31:0]  pc_s;

    logic         ex_s;
    logic         eret_go_s;
    logic         flush_s;
    logic         mtc0_go_s;
    logic [31:0]  ex_pc_s;
    logic [4:0]   exc_code_s;
    bv_sel_t      bv_sel_s;

    logic         wr_count_s;
    logic         wr_compare_s;
    logic         wr_status_s;
    logic         wr_cause_s;
    logic         wr_epc_s;

    logic [7:0]   status_im_r;
    logic         status_exl_r;
    logic         status_ie_r;
    logic         cause_bd_r;
    logic         cause_ti_r;
    logic [1:0]   cause_ip_sw_r;
    logic [5:0]   ext_int_r;
    logic [4:0]   cause_exc_r;
    logic [31:0]  epc_r;
    logic [31:0]  badvaddr_r;
    logic [31:0]  count_r;
    logic [31:0]  compare_r;
    logic         tick_r;

    logic [7:0]   cause_ip_s;
    logic [31:0]  status_s;
    logic [31:0]  cause_s;
    logic [31:0]  cp0_rdata_s;
    logic         has_int_s;
    logic         rf_we_s;
    logic [31:0]  final_result_s;

    assign bad_vaddr_s = bus_r[121:90];
    assign in_slot_s   = bus_r[89];
    assign ex_int_s    = bus_r[88];
    assign adel_if_s   = bus_r[87];
    assign adel_exe_s  = bus_r[86];
    assign rsv_s       = bus_r[85];
    assign ov_s        = bus_r[84];
    assign sys_s       = bus_r[83];
    assign brk_s       = bus_r[82];
    assign ades_s      = bus_r[81];
    assign cp0_addr_s  = bus_r[80:73];
    assign eret_s      = bus_r[72];
    assign mfc0_s      = bus_r[71];
    assign mtc0_s      = bus_r[70];
    assign gr_we_s     = bus_r[69];
    assign dest_s      = bus_r[68:64];
    assign result_s    = bus_r[63:32];
    assign pc_s        = bus_r[31:0];

    // WB never stalls; a flush kills whatever MEM hands over in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_valid_r <= 1'b0;
            bus_r      <= 122'd0;
        end else begin
            ws_valid_r <= flush_s ? 1'b0 : ms_to_ws_valid;
            bus_r      <= ms_to_ws_valid ? ms_to_ws_bus : bus_r;
        end
    end

    assign ex_s      = ws_valid_r & (ex_int_s | adel_if_s | rsv_s | ov_s |
                                     sys_s | brk_s | adel_exe_s | ades_s);
    assign eret_go_s = ws_valid_r & eret_s & ~ex_s;
    assign flush_s   = ex_s | (ws_valid_r & eret_s);
    assign mtc0_go_s = ws_valid_r & mtc0_s & ~ex_s;
    assign ex_pc_s   = eret_go_s ? epc_r : EX_ENTRY;

    // Exception cause priority, and which address (if any) lands in BadVAddr
    always_comb begin
        exc_code_s = 5'd0;
        bv_sel_s   = BV_KEEP;
        if (ex_int_s) begin
            exc_code_s = 5'd0;
        end else if (adel_if_s) begin
            exc_code_s = 5'd4;
            bv_sel_s   = BV_PC;
        end else if (rsv_s) begin
            exc_code_s = 5'd10;
        end else if (ov_s) begin
            exc_code_s = 5'd12;
        end else if (sys_s) begin
            exc_code_s = 5'd8;
        end else if (brk_s) begin
            exc_code_s = 5'd9;
        end else if (adel_exe_s) begin
            exc_code_s = 5'd4;
            bv_sel_s   = BV_ADDR;
        end else if (ades_s) begin
            exc_code_s = 5'd5;
            bv_sel_s   = BV_ADDR;
        end else begin
            exc_code_s = 5'd0;
            bv_sel_s   = BV_KEEP;
        end
    end

    assign wr_count_s   = mtc0_go_s & (cp0_addr_s == ADDR_COUNT);
    assign wr_compare_s = mtc0_go_s & (cp0_addr_s == ADDR_COMPARE);
    assign wr_status_s  = mtc0_go_s & (cp0_addr_s == ADDR_STATUS);
    assign wr_cause_s   = mtc0_go_s & (cp0_addr_s == ADDR_CAUSE);
    assign wr_epc_s     = mtc0_go_s & (cp0_addr_s == ADDR_EPC);

    // Status: exception entry sets EXL, eret clears it, mtc0 loads IM/EXL/IE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_im_r  <= STATUS_RST[15:8];
            status_exl_r <= STATUS_RST[1];
            status_ie_r  <= STATUS_RST[0];
        end else if (ex_s) begin
            status_exl_r <= 1'b1;
        end else if (eret_go_s) begin
            status_exl_r <= 1'b0;
        end else if (wr_status_s) begin
            status_im_r  <= result_s[15:8];
            status_exl_r <= result_s[1];
            status_ie_r  <= result_s[0];
        end else begin
            status_im_r  <= status_im_r;
            status_exl_r <= status_exl_r;
            status_ie_r  <= status_ie_r;
        end
    end

    // Cause: BD only captured on a first-level exception; ExcCode on every exception
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_bd_r    <= 1'b0;
            cause_exc_r   <= 5'd0;
            cause_ip_sw_r <= 2'd0;
            ext_int_r     <= 6'd0;
        end else begin
            ext_int_r <= ext_int_in;
            if (ex_s) begin
                cause_exc_r <= exc_code_s;
                cause_bd_r  <= status_exl_r ? cause_bd_r : in_slot_s;
            end else if (wr_cause_s) begin
                cause_ip_sw_r <= result_s[9:8];
            end else begin
                cause_bd_r    <= cause_bd_r;
                cause_exc_r   <= cause_exc_r;
                cause_ip_sw_r <= cause_ip_sw_r;
            end
        end
    end

    // Timer interrupt flag: a Compare write clears it even if the match fires that cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_ti_r <= 1'b0;
        end else if (wr_compare_s) begin
            cause_ti_r <= 1'b0;
        end else if (count_r == compare_r) begin
            cause_ti_r <= 1'b1;
        end else begin
            cause_ti_r <= cause_ti_r;
        end
    end

    // Count advances every second cycle; a software write restarts the half-rate phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 32'd0;
            tick_r  <= 1'b0;
        end else if (wr_count_s) begin
            count_r <= result_s;
            tick_r  <= 1'b0;
        end else begin
            count_r <= tick_r ? count_r + 32'd1 : count_r;
            tick_r  <= ~tick_r;
        end
    end

    // Compare, EPC and BadVAddr; nested exceptions leave EPC pointing at the outer one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            compare_r  <= 32'd0;
            epc_r      <= 32'd0;
            badvaddr_r <= 32'd0;
        end else begin
            compare_r <= wr_compare_s ? result_s : compare_r;
            if (ex_s && !status_exl_r) begin
                epc_r <= in_slot_s ? pc_s - 32'd4 : pc_s;
            end else if (wr_epc_s) begin
                epc_r <= result_s;
            end else begin
                epc_r <= epc_r;
            end
            if (ex_s && bv_sel_s == BV_PC) begin
                badvaddr_r <= pc_s;
            end else if (ex_s && bv_sel_s == BV_ADDR) begin
                badvaddr_r <= bad_vaddr_s;
            end else begin
                badvaddr_r <= badvaddr_r;
            end
        end
    end

    assign cause_ip_s = {ext_int_r[5] | cause_ti_r, ext_int_r[4:0], cause_ip_sw_r};
    assign status_s   = {9'd0, 1'b1, 6'd0, status_im_r, 6'd0, status_exl_r, status_ie_r};
    assign cause_s    = {cause_bd_r, cause_ti_r, 14'd0, cause_ip_s, 1'b0, cause_exc_r, 2'd0};
    assign has_int_s  = (|(cause_ip_s & status_im_r)) & status_ie_r & ~status_exl_r;

    // CP0 read mux; only sel=0 of each implemented register is decoded
    always_comb begin
        cp0_rdata_s = 32'd0;
        case (cp0_addr_s)
            ADDR_BADVADDR: cp0_rdata_s = badvaddr_r;
            ADDR_COUNT:    cp0_rdata_s = count_r;
            ADDR_COMPARE:  cp0_rdata_s = compare_r;
            ADDR_STATUS:   cp0_rdata_s = status_s;
            ADDR_CAUSE:    cp0_rdata_s = cause_s;
            ADDR_EPC:      cp0_rdata_s = epc_r;
            default:       cp0_rdata_s = 32'd0;
        endcase
    end

    assign rf_we_s        = ws_valid_r & gr_we_s & ~ex_s;
    assign final_result_s = mfc0_s ? cp0_rdata_s : result_s;

    assign ws_allowin                    = 1'b1;
    assign ws_to_rf_bus                  = {rf_we_s, dest_s, final_result_s};
    assign back_to_mem_stage_bus_from_wb = {(rf_we_s ? dest_s : 5'd0), final_result_s};
    assign back_to_id_stage_bus_from_wb  = {mfc0_s, final_result_s, ws_valid_r & gr_we_s, dest_s};
    assign exception_bus                 = {flush_s, ex_pc_s, has_int_s};
    assign debug_wb_pc                   = pc_s;
    assign debug_wb_rf_wen               = {4{rf_we_s}};
    assign debug_wb_rf_wnum              = dest_s;
    assign debug_wb_rf_wdata             = final_result_s;

endmodule
